com_cdc_evt_arb: RTL and testbench
==================================

COM_CDC_EVT_ARB -- requirements
Module: com_cdc_evt_arb

Interface
REQ-001 Parameter N_REQ, default 4: number of pulse requesters, legal range 2..16.
REQ-002 Parameter ID_W, default 2: width of ch_id; SHALL equal ceil(log2(N_REQ)).
REQ-003 Parameter TO_CYC, default 1024: REQ-phase timeout in iclk cycles; 0 disables the timeout.
REQ-004 iclk  in  1  clock; all logic is in this domain.
REQ-005 irst_n  in  1  reset, asynchronous, active-low.
REQ-006 ireq_pulse  in  N_REQ  per-requester event; each cycle a bit is high counts as one event.
REQ-007 ch_ack  in  1  channel acknowledge level, already synchronized into iclk by the caller.
REQ-008 ch_req  out  1  channel request level, 4-phase.
REQ-009 ch_id  out  ID_W  index of the granted requester; valid while ch_req=1.
REQ-010 pend  out  N_REQ  pending-event flags.
REQ-011 busy  out  1  high whenever state is not IDLE.
REQ-012 ovf_pulse  out  N_REQ  one-cycle flag: an event merged into an already-pending one.
REQ-013 to_err  out  1  one-cycle flag: REQ-phase timeout.

Function
REQ-014 pend[i] SHALL set on the edge sampling ireq_pulse[i]=1 and clear only when requester i is granted.
REQ-015 Simultaneous set and grant-clear on the same pend[i]: pend[i] SHALL remain 1, so the new event is kept.
REQ-016 ireq_pulse[i]=1 with pend[i]=1 and no grant of i that cycle SHALL assert ovf_pulse[i] for exactly the next cycle; the event is merged, not counted.
REQ-017 FSM states SHALL be IDLE, REQ and REL, all registered.
REQ-018 IDLE -> REQ SHALL occur when pend is nonzero and ch_ack=0. On that edge: grant g is selected, ch_id<=g, ch_req<=1, pend[g] cleared.
REQ-019 While ch_ack=1 in IDLE, the block SHALL NOT grant (stale ack guard).
REQ-020 Grant selection SHALL be round-robin: the first set pend bit searching upward from last_grant+1, with wrap-around modulo N_REQ.
REQ-021 last_grant SHALL update only on a grant.
REQ-022 REQ state: ch_req and ch_id SHALL be held stable.
REQ-023 REQ -> REL SHALL occur on the edge sampling ch_ack=1; ch_req<=0 on the same edge.
REQ-024 Timeout: a counter SHALL clear on REQ entry and increment each cycle in REQ.
REQ-025 With TO_CYC>0, if the counter reaches TO_CYC-1 with ch_ack=0, then: REQ -> REL, ch_req<=0, to_err=1 for one cycle, and the event is dropped (not re-pended).
REQ-026 REL -> IDLE SHALL occur on the edge sampling ch_ack=0; ch_id holds its value in REL.
REQ-027 ch_ack falling while in REQ SHALL be ignored.
REQ-028 Latency: ireq_pulse sampled at edge t gives pend=1 after t; if IDLE with ch_ack=0, ch_req=1 after edge t+1.
REQ-029 Back-to-back grants SHALL be separated by at least one IDLE cycle.
REQ-030 ovf_pulse and to_err SHALL be registered outputs.

Reset
REQ-031 On irst_n=0 all registers SHALL clear asynchronously: state=IDLE, ch_req=0, ch_id=0, pend=0, busy=0, ovf_pulse=0, to_err=0, timeout counter=0, last_grant=N_REQ-1 (requester 0 wins first).
REQ-032 Reset asserted mid-handshake SHALL drop all pending events and the in-flight request; no to_err is generated.
REQ-033 Release of reset is synchronous to iclk (reset synchronizer external); the first grant SHALL be possible on the first edge after release.

Verification
REQ-034 Single event: ireq_pulse=4'b0100 for 1 cycle; ack responder with 3-cycle delay -> ch_req=1 two edges later with ch_id=2, ch_req falls one edge after ack=1, busy=0 one edge after ack=0, pend=0.
REQ-035 Round-robin: ireq_pulse=4'b1111 for 1 cycle after reset -> grants 0,1,2,3 in order, each a full 4-phase cycle, no ovf_pulse.
REQ-036 Merge/overflow: requester 1 pulses on 3 separate cycles while the channel is busy with requester 0 -> ovf_pulse[1] asserted twice, exactly one later grant of id 1.
REQ-037 Timeout with TO_CYC=8: ack tied 0 -> ch_req high for exactly 8 cycles, to_err one cycle, return to IDLE next edge, next pending requester is then granted.
REQ-038 Stale ack: ch_ack=1 held in IDLE with pend=4'b0001 -> no grant until ack=0, then ch_req=1 the following edge.
REQ-039 Reset mid-REQ: assert irst_n=0 while ch_req=1 and pend=4'b1010 -> all outputs 0 immediately, after release the first grant goes to requester 0 on its next pulse.

Source files
------------

// File: rtl/com_cdc_evt_arb_if.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// com_cdc_evt_arb_if
// Four-phase channel between the event arbiter and the crossing logic.
//   ch_req : request level, driven by the arbiter (master)
//   ch_id  : granted requester index, valid while ch_req is high
//   ch_ack : acknowledge level from the far side. It must already be
//            synchronized into the arbiter's clock domain.
// ---------------------------------------------------------------------------
interface com_cdc_evt_arb_if #(
    parameter int ID_W = 2
);
    logic            ch_req;
    logic [ID_W-1:0] ch_id;
    logic            ch_ack;

    modport master (
        output ch_req,
        output ch_id,
        input  ch_ack
    );

    modport slave (
        input  ch_req,
        input  ch_id,
        output ch_ack
    );
endinterface

// File: rtl/com_cdc_evt_arb.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// com_cdc_evt_arb
// Collects single-cycle events from N_REQ requesters into pending flags.
// It forwards them one at a time over a 4-phase req/ack channel. Requesters
// are served round-robin. An REQ phase that is never acknowledged is
// abandoned after TO_CYC cycles.
//
// Ports
//   iclk        clock
//   irst_n      asynchronous active-low reset. Its release is already
//               synchronized to iclk.
//   ireq_pulse  per-requester event. Each high cycle is one event.
//   ch          channel interface (master side: ch_req/ch_id out, ch_ack in)
//   pend        pending-event flags
//   busy        high while a handshake is in progress (state != IDLE)
//   ovf_pulse   one-cycle flag per requester: an event merged into a
//               pending one
//   to_err      one-cycle flag: the REQ phase timed out and the event was
//               dropped
// ---------------------------------------------------------------------------
module com_cdc_evt_arb #(
    parameter int N_REQ  = 4,
    parameter int ID_W   = 2,
    parameter int TO_CYC = 1024
) (
    input  logic                iclk,
    input  logic                irst_n,
    input  logic [N_REQ-1:0]    ireq_pulse,
    com_cdc_evt_arb_if.master   ch,
    output logic [N_REQ-1:0]    pend,
    output logic                busy,
    output logic [N_REQ-1:0]    ovf_pulse,
    output logic                to_err
);

    // Counter only needs to reach TO_CYC-1. It is kept at least one bit
    // wide so the timeout can be disabled (TO_CYC = 0) without zero-width
    // vectors.
    localparam int CNT_W   = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;
    localparam int TO_LAST = (TO_CYC > 0) ? TO_CYC - 1 : 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        REL  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              ch_req_q, ch_req_d;
    logic [ID_W-1:0]   ch_id_q, ch_id_d;
    logic [ID_W-1:0]   last_grant_q, last_grant_d;
    logic [N_REQ-1:0]  pend_q, pend_d;
    logic [N_REQ-1:0]  ovf_q, ovf_d;
    logic              to_err_q, to_err_d;
    logic [CNT_W-1:0]  to_cnt_q, to_cnt_d;

    logic              grant_en;
    logic [ID_W-1:0]   grant_idx;
    logic [N_REQ-1:0]  grant_mask;
    logic              timeout_hit;
    logic [ID_W:0]     rr_sum;
    logic              rr_found;

    // A stale ack still high from the previous handshake blocks a new
    // grant. Otherwise the far side could see req and ack both high at
    // once.
    assign grant_en = (state_q == IDLE) && (|pend_q) && !ch.ch_ack;

    // Round-robin search: first pending bit at or above last_grant+1,
    // wrapping modulo N_REQ. rr_sum is one bit wider than an index, so
    // last_grant + k (at most 2*N_REQ-1) fits before the wrap subtract.
    always_comb begin
        grant_idx = last_grant_q;
        rr_found  = 1'b0;
        rr_sum    = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            rr_sum = {1'b0, last_grant_q} + (ID_W+1)'(k);
            if (rr_sum >= (ID_W+1)'(N_REQ)) begin
                rr_sum = rr_sum - (ID_W+1)'(N_REQ);
            end
            if (!rr_found && pend_q[rr_sum[ID_W-1:0]]) begin
                grant_idx = rr_sum[ID_W-1:0];
                rr_found  = 1'b1;
            end
        end
    end

    // Per-requester pending and overflow logic. A new event wins over the
    // grant-clear in the same cycle, so it is never lost. An event that
    // lands on a flag which stays pending is merged and reported.
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
        assign grant_mask[gi] = grant_en && (grant_idx == ID_W'(gi));
        assign pend_d[gi]     = (pend_q[gi] & ~grant_mask[gi]) | ireq_pulse[gi];
        assign ovf_d[gi]      = ireq_pulse[gi] & pend_q[gi] & ~grant_mask[gi];
    end

    assign timeout_hit = (TO_CYC > 0) && (to_cnt_q == CNT_W'(TO_LAST));

    // Handshake FSM: next state and registered outputs.
    always_comb begin
        state_d      = state_q;
        ch_req_d     = ch_req_q;
        ch_id_d      = ch_id_q;
        last_grant_d = last_grant_q;
        to_cnt_d     = to_cnt_q;
        to_err_d     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (grant_en) begin
                    state_d      = REQ;
                    ch_req_d     = 1'b1;
                    ch_id_d      = grant_idx;
                    last_grant_d = grant_idx;
                    to_cnt_d     = '0;
                end
            end
            REQ: begin
                to_cnt_d = to_cnt_q + CNT_W'(1);
                // An ack always wins over a timeout on the same edge.
                // A falling ack here cannot happen legally and is ignored.
                if (ch.ch_ack) begin
                    state_d  = REL;
                    ch_req_d = 1'b0;
                end else if (timeout_hit) begin
                    // The event is abandoned. Its pend bit was cleared at
                    // grant time and is not restored.
                    state_d  = REL;
                    ch_req_d = 1'b0;
                    to_err_d = 1'b1;
                end
            end
            REL: begin
                if (!ch.ch_ack) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d  = IDLE;
                ch_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            state_q      <= IDLE;
            ch_req_q     <= 1'b0;
            ch_id_q      <= '0;
            last_grant_q <= ID_W'(N_REQ - 1);   // requester 0 wins first
            pend_q       <= '0;
            ovf_q        <= '0;
            to_err_q     <= 1'b0;
            to_cnt_q     <= '0;
        end else begin
            state_q      <= state_d;
            ch_req_q     <= ch_req_d;
            ch_id_q      <= ch_id_d;
            last_grant_q <= last_grant_d;
            pend_q       <= pend_d;
            ovf_q        <= ovf_d;
            to_err_q     <= to_err_d;
            to_cnt_q     <= to_cnt_d;
        end
    end

    assign ch.ch_req = ch_req_q;
    assign ch.ch_id  = ch_id_q;
    assign pend      = pend_q;
    assign busy      = (state_q != IDLE);
    assign ovf_pulse = ovf_q;
    assign to_err    = to_err_q;

endmodule

// File: tb/tb_com_cdc_evt_arb.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_com_cdc_evt_arb
// Self-checking bench for com_cdc_evt_arb (N_REQ=4, TO_CYC=8).
// The reference model tracks three things: the phase of the handshake, a
// pending-event set, and the cycle at which the current grant was issued.
// ---------------------------------------------------------------------------
module tb_com_cdc_evt_arb;
    localparam int N  = 4;
    localparam int IW = 2;
    localparam int TO = 8;
    localparam int VW = 1 + IW + N + 1 + N + 1;

    logic          iclk = 1'b0;
    logic          irst_n = 1'b0;
    logic [N-1:0]  ireq_pulse = '0;
    logic [N-1:0]  pend, ovf_pulse;
    logic          busy, to_err;

    com_cdc_evt_arb_if #(.ID_W(IW)) chif();

    com_cdc_evt_arb #(.N_REQ(N), .ID_W(IW), .TO_CYC(TO)) dut (
        .iclk       (iclk),
        .irst_n     (irst_n),
        .ireq_pulse (ireq_pulse),
        .ch         (chif),
        .pend       (pend),
        .busy       (busy),
        .ovf_pulse  (ovf_pulse),
        .to_err     (to_err)
    );

    always #5 iclk = ~iclk;

    // Reference model state. Phase: 0 idle, 1 waiting for ack, 2 waiting
    // for ack release.
    int            m_phase;
    logic [N-1:0]  m_pend, m_ovf;
    logic          m_req, m_to;
    logic [IW-1:0] m_id;
    int            m_last, m_cyc, m_gcyc;

    int n_checks = 0;
    int n_fail   = 0;

    // Ack responder. Mode 0: the test drives ch_ack by hand. Mode 1: ch_ack
    // follows ch_req after resp_dly cycles. Mode 2: ch_ack is random.
    int ack_mode, resp_dly, resp_cnt;

    // Observations taken from the DUT.
    int   dut_grants[$];
    logic prev_req;
    int   ovf_seen[N];
    int   to_seen;

    task automatic model_reset();
        m_phase = 0; m_pend = '0; m_ovf = '0; m_req = 1'b0; m_to = 1'b0;
        m_id = '0; m_last = N - 1; m_cyc = 0; m_gcyc = 0;
    endtask

    task automatic model_step(input logic [N-1:0] p, input logic a);
        int g;
        g = -1; m_ovf = '0; m_to = 1'b0;
        if (m_phase == 0) begin
            if (m_pend != 0 && !a) begin
                for (int k = 1; k <= N; k++) begin
                    int c;
                    c = (m_last + k) % N;
                    if (g < 0 && m_pend[c]) g = c;
                end
                m_phase = 1; m_req = 1'b1; m_id = IW'(g); m_last = g; m_gcyc = m_cyc;
            end
        end else if (m_phase == 1) begin
            if (a) begin
                m_phase = 2; m_req = 1'b0;
            end else if (m_cyc - m_gcyc == TO) begin
                m_phase = 2; m_req = 1'b0; m_to = 1'b1;
            end
        end else if (!a) begin
            m_phase = 0;
        end
        for (int i = 0; i < N; i++) begin
            if (p[i] && m_pend[i] && i != g) m_ovf[i] = 1'b1;
            if (i == g) m_pend[i] = 1'b0;
            if (p[i]) m_pend[i] = 1'b1;
        end
        m_cyc++;
    endtask

    // ch_id is only compared while a handshake is in progress. Outside a
    // handshake it is a don't-care.
    function automatic logic [VW-1:0] exp_vec();
        return {m_req, m_id, m_pend, (m_phase != 0), m_ovf, m_to};
    endfunction

    function automatic logic [VW-1:0] dut_vec();
        return {chif.ch_req, (m_phase != 0) ? chif.ch_id : m_id, pend, busy, ovf_pulse, to_err};
    endfunction

    // This task only advances time. It steps the model on the inputs
    // presented at this negedge, lets the DUT clock, and records what the
    // DUT shows at the next negedge.
    task automatic tick();
        if (ack_mode == 1) begin
            if (chif.ch_req !== chif.ch_ack) begin
                resp_cnt++;
                if (resp_cnt >= resp_dly) begin
                    chif.ch_ack = chif.ch_req;
                    resp_cnt = 0;
                end
            end else begin
                resp_cnt = 0;
            end
        end else if (ack_mode == 2) begin
            chif.ch_ack = ($urandom_range(0, 2) == 0);
        end
        model_step(ireq_pulse, chif.ch_ack);
        @(posedge iclk);
        @(negedge iclk);
        if (chif.ch_req === 1'b1 && prev_req !== 1'b1) dut_grants.push_back(int'(chif.ch_id));
        prev_req = chif.ch_req;
        for (int i = 0; i < N; i++) if (ovf_pulse[i] === 1'b1) ovf_seen[i]++;
        if (to_err === 1'b1) to_seen++;
    endtask

    task automatic apply_reset();
        #2;
        irst_n = 1'b0; chif.ch_ack = 1'b0; ireq_pulse = '0;
        model_reset();
        #1;
    endtask

    task automatic release_reset();
        @(negedge iclk);
        irst_n = 1'b1;
        ack_mode = 0; resp_cnt = 0; prev_req = 1'b0; to_seen = 0;
        dut_grants.delete();
        for (int i = 0; i < N; i++) ovf_seen[i] = 0;
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++;
        if (dut_vec() !== exp_vec() || chif.ch_id !== '0) begin
            n_fail++;
            $display("FAIL reset_async got=%b id=%0d exp=%b id=0", dut_vec(), chif.ch_id, exp_vec());
        end
        ireq_pulse = '1;
        @(posedge iclk); @(negedge iclk);
        n_checks++;
        if (pend !== '0 || chif.ch_req !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_held pend=%b req=%b busy=%b exp all 0", pend, chif.ch_req, busy);
        end
        ireq_pulse = '0;
        release_reset();
        $display("test_reset done");
    endtask

    task automatic test_single_event();
        apply_reset(); release_reset();
        ack_mode = 1; resp_dly = 3;
        ireq_pulse = 4'b0100; tick(); ireq_pulse = '0;
        n_checks++;
        if (pend !== 4'b0100 || chif.ch_req !== 1'b0) begin
            n_fail++;
            $display("FAIL single_latch pend=%b req=%b exp pend=0100 req=0", pend, chif.ch_req);
        end
        tick();
        n_checks++;
        if (chif.ch_req !== 1'b1 || chif.ch_id !== 2'd2) begin
            n_fail++;
            $display("FAIL single_grant req=%b id=%0d exp req=1 id=2", chif.ch_req, chif.ch_id);
        end
        for (int c = 0; c < 20; c++) begin
            tick();
            n_checks++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL single_model cyc=%0d got=%b exp=%b", c, dut_vec(), exp_vec());
            end
        end
        n_checks++;
        if (pend !== '0 || busy !== 1'b0 || dut_grants.size() != 1) begin
            n_fail++;
            $display("FAIL single_end pend=%b busy=%b grants=%0d exp 0,0,1", pend, busy, dut_grants.size());
        end
        $display("test_single_event done grants=%0d", dut_grants.size());
    endtask

    task automatic test_round_robin();
        apply_reset(); release_reset();
        ack_mode = 1; resp_dly = $urandom_range(1, 4);
        ireq_pulse = 4'b1111; tick(); ireq_pulse = '0;
        for (int c = 0; c < 80; c++) begin
            tick();
            n_checks++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL rr_model cyc=%0d got=%b exp=%b", c, dut_vec(), exp_vec());
            end
        end
        n_checks++;
        if (dut_grants.size() != 4) begin
            n_fail++;
            $display("FAIL rr_count got=%0d exp=4", dut_grants.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                n_checks++;
                if (dut_grants[k] != k) begin
                    n_fail++;
                    $display("FAIL rr_order slot=%0d got=%0d exp=%0d", k, dut_grants[k], k);
                end
            end
        end
        n_checks++;
        if (ovf_seen[0] + ovf_seen[1] + ovf_seen[2] + ovf_seen[3] != 0) begin
            n_fail++;
            $display("FAIL rr_ovf got=%0d exp=0", ovf_seen[0] + ovf_seen[1] + ovf_seen[2] + ovf_seen[3]);
        end
        $display("test_round_robin done dly=%0d grants=%0d", resp_dly, dut_grants.size());
    endtask

    task automatic test_merge();
        int ones;
        apply_reset(); release_reset();
        ack_mode = 1; resp_dly = 6;
        ireq_pulse = 4'b0001; tick(); ireq_pulse = '0;
        tick();
        for (int c = 0; c < 5; c++) begin
            ireq_pulse = (c % 2 == 0) ? 4'b0010 : 4'b0000;
            tick();
            n_checks++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL merge_model cyc=%0d got=%b exp=%b", c, dut_vec(), exp_vec());
            end
        end
        ireq_pulse = '0;
        for (int c = 0; c < 40; c++) begin
            tick();
            n_checks++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL merge_model2 cyc=%0d got=%b exp=%b", c, dut_vec(), exp_vec());
            end
        end
        ones = 0;
        foreach (dut_grants[k]) if (dut_grants[k] == 1) ones++;
        n_checks++;
        if (ovf_seen[1] != 2 || ones != 1 || dut_grants.size() != 2) begin
            n_fail++;
            $display("FAIL merge_result ovf1=%0d id1_grants=%0d grants=%0d exp 2,1,2", ovf_seen[1], ones, dut_grants.size());
        end
        $display("test_merge done ovf1=%0d id1_grants=%0d", ovf_seen[1], ones);
    endtask

    task automatic test_timeout();
        int hi;
        apply_reset(); release_reset();
        ack_mode = 0; chif.ch_ack = 1'b0;
        ireq_pulse = 4'b0011; tick(); ireq_pulse = '0;
        hi = 0;
        for (int c = 0; c < 30 && to_seen == 0; c++) begin
            tick();
            n_checks++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL to_model cyc=%0d got=%b exp=%b", c, dut_vec(), exp_vec());
            end
            if (chif.ch_req === 1'b1) hi++;
        end
        n_checks++;
        if (hi != 8 || to_seen != 1) begin
            n_fail++;
            $display("FAIL to_length req_high=%0d to_err=%0d exp 8,1", hi, to_seen);
        end
        tick();
        n_checks++;
        if (busy !== 1'b0 || to_err !== 1'b0) begin
            n_fail++;
            $display("FAIL to_idle busy=%b to_err=%b exp 0,0", busy, to_err);
        end
        tick();
        n_checks++;
        if (chif.ch_req !== 1'b1 || chif.ch_id !== 2'd1) begin
            n_fail++;
            $display("FAIL to_next req=%b id=%0d exp req=1 id=1", chif.ch_req, chif.ch_id);
        end
        ack_mode = 1; resp_dly = 2;
        for (int c = 0; c < 15; c++) begin
            tick();
            n_checks++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL to_model2 cyc=%0d got=%b exp=%b", c, dut_vec(), exp_vec());
            end
        end
        $display("test_timeout done req_high=%0d to_err=%0d", hi, to_seen);
    endtask

    task automatic test_stale_ack();
        apply_reset(); release_reset();
        ack_mode = 0; chif.ch_ack = 1'b1;
        ireq_pulse = 4'b0001; tick(); ireq_pulse = '0;
        for (int c = 0; c < 5; c++) begin
            tick();
            n_checks++;
            if (chif.ch_req !== 1'b0 || pend !== 4'b0001 || dut_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL stale_hold cyc=%0d req=%b pend=%b exp req=0 pend=0001", c, chif.ch_req, pend);
            end
        end
        chif.ch_ack = 1'b0;
        tick();
        n_checks++;
        if (chif.ch_req !== 1'b1 || chif.ch_id !== 2'd0) begin
            n_fail++;
            $display("FAIL stale_grant req=%b id=%0d exp req=1 id=0", chif.ch_req, chif.ch_id);
        end
        ack_mode = 1; resp_dly = 2;
        for (int c = 0; c < 12; c++) tick();
        $display("test_stale_ack done");
    endtask

    task automatic test_reset_mid_req();
        apply_reset(); release_reset();
        ack_mode = 0; chif.ch_ack = 1'b0;
        ireq_pulse = 4'b0001; tick(); ireq_pulse = '0;
        tick();
        ireq_pulse = 4'b1010; tick(); ireq_pulse = '0;
        n_checks++;
        if (chif.ch_req !== 1'b1 || pend !== 4'b1010) begin
            n_fail++;
            $display("FAIL midrst_setup req=%b pend=%b exp req=1 pend=1010", chif.ch_req, pend);
        end
        apply_reset();
        n_checks++;
        if ({chif.ch_req, chif.ch_id, pend, busy, ovf_pulse, to_err} !== '0) begin
            n_fail++;
            $display("FAIL midrst_clear got=%b exp=0", {chif.ch_req, chif.ch_id, pend, busy, ovf_pulse, to_err});
        end
        @(posedge iclk); @(negedge iclk);
        release_reset();
        ireq_pulse = 4'b1001; tick(); ireq_pulse = '0;
        tick();
        n_checks++;
        if (chif.ch_req !== 1'b1 || chif.ch_id !== 2'd0 || to_seen != 0 || dut_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL midrst_first req=%b id=%0d to_err=%0d exp req=1 id=0 to_err=0", chif.ch_req, chif.ch_id, to_seen);
        end
        ack_mode = 1; resp_dly = 1;
        for (int c = 0; c < 20; c++) tick();
        $display("test_reset_mid_req done");
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        apply_reset(); release_reset();
        ack_mode = 1; resp_dly = 2;
        for (int c = 0; c < 3000; c++) begin
            if (c % 50 == 0) begin
                ack_mode = ($urandom_range(0, 4) == 0) ? 2 : 1;
                resp_dly = ($urandom_range(0, 5) == 0) ? 12 : $urandom_range(0, 5);
            end
            for (int i = 0; i < N; i++) ireq_pulse[i] = ($urandom_range(0, 5) == 0);
            tick();
            n_checks++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++; errs++;
                if (errs < 20) $display("FAIL rand_model cyc=%0d got=%b exp=%b", c, dut_vec(), exp_vec());
            end
        end
        ireq_pulse = '0;
        $display("test_random done grants=%0d timeouts=%0d", dut_grants.size(), to_seen);
    endtask

    initial begin
        chif.ch_ack = 1'b0;
        ack_mode = 0; resp_dly = 0; resp_cnt = 0; prev_req = 1'b0; to_seen = 0;
        for (int i = 0; i < N; i++) ovf_seen[i] = 0;
        model_reset();
        @(negedge iclk);
        test_reset();
        test_single_event();
        test_round_robin();
        test_merge();
        test_timeout();
        test_stale_ack();
        test_reset_mid_req();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
